// File: rtl/gshare_predictor.sv
// ---------------------------------------------------------------------------
// gshare_predictor
//
// Parametrised gshare conditional-branch predictor for the IF unit.
// A table of 2^INDEX_LEN saturating counters is indexed by the PC word
// address XORed with a global history register (GHR). The GHR shifts in
// each predicted BRANCH direction at fetch and is restored from the
// ROB-supplied snapshot when a committed branch turns out mispredicted.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   query_valid       fetch stage presents an instruction this cycle
//   query_pc          PC of the fetched instruction
//   query_inst        fetched instruction word
//   predicted_jump    predict taken (combinational)
//   predicted_imm     sign-extended J-imm for JAL, otherwise B-imm
//   predicted_ghr     GHR used for this prediction (travels to the ROB)
//   upd_valid         ROB commits a conditional branch
//   upd_taken         resolved direction
//   upd_mispredict    resolved direction differs from the prediction
//   upd_pc            PC of the committed branch
//   upd_ghr           predicted_ghr snapshot carried with that branch
//   stat_branches     committed branch count, saturating
//   stat_mispredicts  mispredict count, saturating
// ---------------------------------------------------------------------------
module gshare_predictor #(
    parameter int INDEX_LEN = 8,
    parameter int HIST_LEN  = 8,
    parameter int CNT_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                query_valid,
    input  logic [31:0]         query_pc,
    input  logic [31:0]         query_inst,
    output logic                predicted_jump,
    output logic [31:0]         predicted_imm,
    output logic [HIST_LEN-1:0] predicted_ghr,
    input  logic                upd_valid,
    input  logic                upd_taken,
    input  logic                upd_mispredict,
    input  logic [31:0]         upd_pc,
    input  logic [HIST_LEN-1:0] upd_ghr,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
);

    localparam int DEPTH = 1 << INDEX_LEN;

    // Weakly-not-taken: MSB clear, all lower bits set.
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Table index: PC word address XOR zero-extended history.
    function automatic logic [INDEX_LEN-1:0] table_index(
        input logic [31:0]         pc,
        input logic [HIST_LEN-1:0] hist
    );
        logic [INDEX_LEN-1:0] hist_ext;
        hist_ext    = INDEX_LEN'(hist);
        table_index = pc[INDEX_LEN+1:2] ^ hist_ext;
    endfunction

    // Shift one outcome into a history value. Appending the bit below the
    // full history and keeping the low HIST_LEN bits also covers HIST_LEN=1.
    function automatic logic [HIST_LEN-1:0] hist_push(
        input logic [HIST_LEN-1:0] hist,
        input logic                outcome
    );
        logic [HIST_LEN:0] wide;
        wide      = {hist, outcome};
        hist_push = wide[HIST_LEN-1:0];
    endfunction

    // Saturating up/down step for one prediction counter.
    function automatic logic [CNT_WIDTH-1:0] cnt_step(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 taken
    );
        if (taken) begin
            cnt_step = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        end else begin
            cnt_step = (cnt == CNT_ZERO) ? cnt : cnt - CNT_ONE;
        end
    endfunction

    // Saturating increment for the 32-bit statistics counters.
    function automatic logic [31:0] stat_inc(
        input logic [31:0] value,
        input logic        enable
    );
        if (enable && (value != STAT_MAX)) begin
            stat_inc = value + 32'd1;
        end else begin
            stat_inc = value;
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] table_r [DEPTH];
    logic [HIST_LEN-1:0]  ghr_r;
    logic [31:0]          stat_branches_r;
    logic [31:0]          stat_mispredicts_r;

    logic [INDEX_LEN-1:0] query_idx_s;
    logic [INDEX_LEN-1:0] upd_idx_s;
    logic [6:0]           opcode_s;
    logic                 is_branch_s;
    logic [31:0]          imm_b_s;
    logic [31:0]          imm_j_s;
    logic                 jump_s;
    logic                 recover_s;

    // Bits of the PCs that never reach the index are collected here so
    // they are visibly consumed.
    logic                 unused_s;

    assign unused_s = ^{query_pc[31:INDEX_LEN+2], query_pc[1:0],
                        upd_pc[31:INDEX_LEN+2], upd_pc[1:0]};

    assign query_idx_s = table_index(query_pc, ghr_r);
    assign upd_idx_s   = table_index(upd_pc, upd_ghr);
    assign opcode_s    = query_inst[6:0];
    assign is_branch_s = (opcode_s == OPC_BRANCH);
    assign recover_s   = upd_valid && upd_mispredict;

    assign imm_b_s = {{20{query_inst[31]}}, query_inst[7], query_inst[30:25],
                      query_inst[11:8], 1'b0};
    assign imm_j_s = {{12{query_inst[31]}}, query_inst[19:12], query_inst[20],
                      query_inst[30:21], 1'b0};

    // Direction decode: JAL always taken, BRANCH follows counter MSB.
    // The table read sees the pre-update value even when an update to the
    // same entry is in flight this cycle.
    always_comb begin
        jump_s = 1'b0;
        case (opcode_s)
            OPC_JAL:    jump_s = 1'b1;
            OPC_BRANCH: jump_s = table_r[query_idx_s][CNT_WIDTH-1];
            default:    jump_s = 1'b0;
        endcase
    end

    // Immediate select: J-imm for JAL, B-imm for everything else.
    always_comb begin
        if (opcode_s == OPC_JAL) begin
            predicted_imm = imm_j_s;
        end else begin
            predicted_imm = imm_b_s;
        end
    end

    assign predicted_jump   = jump_s;
    assign predicted_ghr    = ghr_r;
    assign stat_branches    = stat_branches_r;
    assign stat_mispredicts = stat_mispredicts_r;

    // Global history: recovery from the ROB snapshot wins over the
    // speculative shift of a BRANCH fetched in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_r <= {HIST_LEN{1'b0}};
        end else if (recover_s) begin
            ghr_r <= hist_push(upd_ghr, upd_taken);
        end else if (query_valid && is_branch_s) begin
            ghr_r <= hist_push(ghr_r, jump_s);
        end else begin
            ghr_r <= ghr_r;
        end
    end

    // Counter table: reset every entry to weakly-not-taken, then train the
    // entry addressed by the committed branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_r[i] <= CNT_INIT;
            end
        end else if (upd_valid) begin
            table_r[upd_idx_s] <= cnt_step(table_r[upd_idx_s], upd_taken);
        end else begin
            table_r[upd_idx_s] <= table_r[upd_idx_s];
        end
    end

    // Performance statistics, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_r    <= 32'd0;
            stat_mispredicts_r <= 32'd0;
        end else begin
            stat_branches_r    <= stat_inc(stat_branches_r, upd_valid);
            stat_mispredicts_r <= stat_inc(stat_mispredicts_r, recover_s);
        end
    end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised gshare conditional-branch predictor for the IF unit. It is the next generation of the per-PC 2-bit BHT: counter width, table depth and history length are parameters. The table is indexed by PC XOR a global history register (GHR); the GHR is updated speculatively at fetch and restored from a ROB-supplied snapshot on mispredict. Prediction is combinational for the fetch stage; table and history update on the clock edge; saturating statistics counters are exported for performance debug.

## Interface

- INDEX_LEN, 8, table index width; table holds 2^INDEX_LEN counters
- HIST_LEN, 8, GHR width; legal range 1..INDEX_LEN
- CNT_WIDTH, 2, saturating counter width; minimum 2
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- query_valid  input  1  fetch stage presents an instruction this cycle
- query_pc  input  32  PC of the fetched instruction
- query_inst  input  32  fetched instruction word
- predicted_jump  output  1  predict taken
- predicted_imm  output  32  sign-extended J-imm for JAL, otherwise B-imm
- predicted_ghr  output  HIST_LEN  GHR value used for this prediction; travels with the instruction to the ROB
- upd_valid  input  1  ROB commits a conditional branch
- upd_taken  input  1  resolved direction
- upd_mispredict  input  1  resolved direction differs from the prediction
- upd_pc  input  32  PC of the committed branch
- upd_ghr  input  HIST_LEN  predicted_ghr snapshot carried with that branch
- stat_branches  output  32  committed branch count, saturating
- stat_mispredicts  output  32  mispredict count, saturating

## Operation

- Index: idx = query_pc[INDEX_LEN+1:2] XOR zero-extend(ghr). The update index uses upd_pc and upd_ghr in the same way.
- Prediction is combinational and independent of query_valid:
  - opcode JAL (1101111) -> 1
  - opcode BRANCH (1100011) -> MSB of counter[idx]
  - any other opcode, including JALR -> 0
- predicted_ghr = current ghr, before any shift this cycle.
- Speculative history: on query_valid with opcode BRANCH, ghr <= {ghr[HIST_LEN-2:0], predicted_jump}. JAL does not shift the GHR. With HIST_LEN = 1, ghr <= predicted_jump.
- Recovery: on upd_valid && upd_mispredict, ghr <= {upd_ghr[HIST_LEN-2:0], upd_taken}. Recovery has priority over a speculative shift in the same cycle; that shift is discarded.
- Counter training: on upd_valid, counter[upd_idx] increments if upd_taken and decrements otherwise.
  - Saturates at all-ones and at 0; no wrap.
  - Width is CNT_WIDTH; arithmetic is unsigned.
- Statistics:
  - stat_branches increments on every upd_valid.
  - stat_mispredicts increments on upd_valid && upd_mispredict.
  - Both hold at 0xFFFFFFFF once reached.
- upd_mispredict without upd_valid is ignored.

## Timing

- Reset (rst high at a posedge):
  - every counter = weakly-not-taken = 2^(CNT_WIDTH-1)-1 (01 for CNT_WIDTH = 2)
  - ghr = 0; stat_branches = stat_mispredicts = 0
  - predicted_jump from reset state: 1 for JAL, 0 for BRANCH, 0 for all other opcodes
- rst overrides query and update inputs in the same cycle; reset in mid-operation discards all history. rst is level-sensitive; all state holds reset values while it is asserted.
- Prediction latency is 0 cycles (same cycle as query).
- GHR, counter and statistics updates are visible 1 cycle after the edge that samples them.
- Same-cycle query and update to the same index: the prediction uses the pre-update counter value. The write lands at the edge.
- Back-to-back updates to the same index on consecutive cycles each apply; the second one sees the first one's result.
- No handshake or backpressure: every update is accepted, one per cycle.

## Test plan

- Reset, then query BRANCH 0xFE000CE3 at PC 0x100 -> predicted_jump = 0, predicted_imm = 0xFFFFFFF8, predicted_ghr = 0x00. Query JAL 0x0100006F -> predicted_jump = 1, predicted_imm = 0x00000010. Query JALR -> predicted_jump = 0.
- Saturation: upd_valid, upd_taken = 1, upd_pc = 0x100, upd_ghr = 0 on three cycles -> counter[0x40] goes 01→10→11→11; query at 0x100 with ghr 0 predicts 1. Then two not-taken updates -> counter 01; prediction 0.
- Speculative history: with counter[0x40] = 11, query_valid BRANCH at 0x100 -> next cycle ghr = 0x01. Query_valid JAL -> ghr unchanged.
- Recovery priority: in the same cycle, query_valid BRANCH predicted taken, and upd_valid, upd_mispredict = 1, upd_ghr = 0x05, upd_taken = 1 -> next cycle ghr = 0x0B, not the speculative value. stat_mispredicts increments by 1.
- XOR indexing: set ghr = 0x40 via recovery, then train upd_pc = 0x100 with upd_ghr = 0x40 -> counter[0x00] changes and counter[0x40] is untouched.
- Statistics and reset: preload stat_branches near 0xFFFFFFFF by forcing the register, apply 3 updates -> holds at 0xFFFFFFFF. Assert rst mid-stream -> both statistics counters, ghr and every counter return to reset values on the next edge.
